// File: rtl/apb_debug_requester.sv
// apb_debug_requester: valid/ready command to single APB transfer bridge for the 8-bit debug port.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles (rsp_timeout=1, rdata=8'hFF).
module apb_debug_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_addr,
  input  logic       cmd_write,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_write,
  output logic       rsp_timeout,
  output logic       PSEL,
  output logic       PENABLE,
  output logic [7:0] PADDR,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic       init_q;
  logic [7:0] paddr_q, pwdata_q, rdata_q;
  logic       pwrite_q, rwrite_q, rtimeout_q;
  logic       accept, abort, done;
`ifdef APB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  // abort on the edge where the wait counter would reach the limit
  assign abort = state_q == ACCESS && !PREADY && cnt_q == 8'(TIMEOUT_CYCLES - 1);
  assign cnt_d = (state_q == ACCESS && !PREADY) ? cnt_q + 8'd1 : 8'd0;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
`else
  assign abort = 1'b0;
`endif
  assign accept = cmd_valid && cmd_ready;
  assign done = state_q == ACCESS && (PREADY || abort);
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state_q    <= IDLE;
      init_q     <= 1'b0;
      paddr_q    <= 8'd0;
      pwdata_q   <= 8'd0;
      pwrite_q   <= 1'b0;
      rdata_q    <= 8'd0;
      rwrite_q   <= 1'b0;
      rtimeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (accept) begin
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
        pwrite_q <= cmd_write;
      end
      if (done) begin
        rdata_q    <= !PREADY ? 8'hFF : pwrite_q ? 8'h00 : PRDATA;
        rwrite_q   <= pwrite_q;
        rtimeout_q <= !PREADY;
      end
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = done ? RESP : ACCESS;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // init_q keeps cmd_ready low while reset is held
  always_comb begin
    cmd_ready = init_q && state_q == IDLE;
    PSEL      = state_q == SETUP || state_q == ACCESS;
    PENABLE   = state_q == ACCESS;
    rsp_valid = state_q == RESP;
  end
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_write   = rwrite_q;
  assign rsp_timeout = rtimeout_q;
endmodule

// File: tb/tb_apb_debug_requester.sv
// tb_apb_debug_requester: directed self-checking bench for apb_debug_requester.
module tb_apb_debug_requester;
  logic PCLK = 0, PRESETn = 0, cmd_valid = 0, cmd_write = 0, rsp_ready = 0, PREADY = 0;
  logic [7:0] cmd_addr = 0, cmd_wdata = 0, PRDATA = 0;
  logic cmd_ready, rsp_valid, rsp_write, rsp_timeout, PSEL, PENABLE, PWRITE;
  logic [7:0] rsp_rdata, PADDR, PWDATA;
  int n_cmp = 0, n_err = 0;

  always #5 PCLK = ~PCLK;

  apb_debug_requester #(.TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset;
    PRESETn = 0;
    #2;
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000) begin
      $display("FAIL reset_ctl: got %b want 0000", {PSEL, PENABLE, rsp_valid, cmd_ready});
      n_err++;
    end
    n_cmp++;
    if ({PADDR, PWDATA, rsp_rdata, PWRITE, rsp_write, rsp_timeout} !== 27'd0) begin
      $display("FAIL reset_regs: got %h want 0", {PADDR, PWDATA, rsp_rdata, PWRITE, rsp_write, rsp_timeout});
      n_err++;
    end
    tick();
    #3 PRESETn = 1;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
      $display("FAIL reset_release: got %b want 0001", {PSEL, PENABLE, rsp_valid, cmd_ready});
      n_err++;
    end
  endtask

  task automatic test_read;
    cmd_valid = 1; cmd_addr = 8'h09; cmd_write = 0; PRDATA = 8'h5A; PREADY = 0;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready, PADDR, PWRITE} !== {4'b1000, 8'h09, 1'b0}) begin
      $display("FAIL read_setup: got %b/%h/%b want 1000/09/0", {PSEL, PENABLE, rsp_valid, cmd_ready}, PADDR, PWRITE);
      n_err++;
    end
    cmd_valid = 0;
    PREADY = 1;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b1100) begin
      $display("FAIL read_access: got %b want 1100", {PSEL, PENABLE, rsp_valid, cmd_ready});
      n_err++;
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready, rsp_rdata, rsp_write} !== {4'b0010, 8'h5A, 1'b0}) begin
      $display("FAIL read_resp: got %b/%h/%b want 0010/5a/0", {PSEL, PENABLE, rsp_valid, cmd_ready}, rsp_rdata, rsp_write);
      n_err++;
    end
    PREADY = 0;
    rsp_ready = 1;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
      $display("FAIL read_idle: got %b want 0001", {PSEL, PENABLE, rsp_valid, cmd_ready});
      n_err++;
    end
    rsp_ready = 0;
  endtask

  task automatic test_write_wait;
    cmd_valid = 1; cmd_addr = 8'h0A; cmd_write = 1; cmd_wdata = 8'hC3; PRDATA = 8'h77;
    tick();
    n_cmp++;
    if ({PWRITE, PWDATA} !== {1'b1, 8'hC3}) begin
      $display("FAIL write_setup: got %b/%h want 1/c3", PWRITE, PWDATA);
      n_err++;
    end
    cmd_valid = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) PREADY = 1;
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid, PADDR, PWDATA} !== {3'b110, 8'h0A, 8'hC3}) begin
        $display("FAIL write_wait%0d: got %b/%h/%h want 110/0a/c3", i, {PSEL, PENABLE, rsp_valid}, PADDR, PWDATA);
        n_err++;
      end
      tick();
    end
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready, rsp_rdata, rsp_write} !== {4'b0010, 8'h00, 1'b1}) begin
      $display("FAIL write_resp: got %b/%h/%b want 0010/00/1", {PSEL, PENABLE, rsp_valid, cmd_ready}, rsp_rdata, rsp_write);
      n_err++;
    end
    PREADY = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
      $display("FAIL write_single: got %b want 0001", {PSEL, PENABLE, rsp_valid, cmd_ready});
      n_err++;
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    cmd_valid = 1; cmd_addr = 8'h01; cmd_write = 0; PREADY = 1; PRDATA = 8'h11;
    tick();
    cmd_addr = 8'h02;
    tick();
    gap = 0;
    tick();
    PRDATA = 8'h22;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready, rsp_rdata, PADDR} !== {4'b0010, 8'h11, 8'h01}) begin
        $display("FAIL b2b_stall%0d: got %b/%h/%h want 0010/11/01", i, {PSEL, PENABLE, rsp_valid, cmd_ready}, rsp_rdata, PADDR);
        n_err++;
      end
      if (!PENABLE) gap++;
      tick();
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
      $display("FAIL b2b_idle: got %b want 0001", {PSEL, PENABLE, rsp_valid, cmd_ready});
      n_err++;
    end
    if (!PENABLE) gap++;
    tick();
    cmd_valid = 0;
    n_cmp++;
    if ({PSEL, PENABLE, PADDR} !== {2'b10, 8'h02}) begin
      $display("FAIL b2b_setup2: got %b/%h want 10/02", {PSEL, PENABLE}, PADDR);
      n_err++;
    end
    if (!PENABLE) gap++;
    tick();
    n_cmp++;
    if (PENABLE !== 1'b1 || gap < 2) begin
      $display("FAIL b2b_gap: penable %b gap %0d want 1 and >=2", PENABLE, gap);
      n_err++;
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h22}) begin
      $display("FAIL b2b_resp2: got %b/%h want 1/22", rsp_valid, rsp_rdata);
      n_err++;
    end
    PREADY = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_busy;
    cmd_valid = 1; cmd_addr = 8'h30; cmd_write = 0; PREADY = 0;
    tick();
    cmd_addr = 8'hEE;
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready, PADDR} !== {4'b1100, 8'h30}) begin
        $display("FAIL busy_hold%0d: got %b/%h want 1100/30", i, {PSEL, PENABLE, rsp_valid, cmd_ready}, PADDR);
        n_err++;
      end
    end
    cmd_valid = 0; PREADY = 1; PRDATA = 8'h44;
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h44}) begin
      $display("FAIL busy_resp: got %b/%h want 1/44", rsp_valid, rsp_rdata);
      n_err++;
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
        $display("FAIL idle_pready%0d: got %b want 0001", i, {PSEL, PENABLE, rsp_valid, cmd_ready});
        n_err++;
      end
    end
    PREADY = 0;
  endtask

  task automatic test_async_reset;
    cmd_valid = 1; cmd_addr = 8'h40; cmd_write = 0; PREADY = 0;
    tick();
    cmd_valid = 0;
    tick();
    #3 PRESETn = 0;
    #1;
    n_cmp++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready, PADDR} !== {4'b0000, 8'h00}) begin
      $display("FAIL areset_now: got %b/%h want 0000/00", {PSEL, PENABLE, rsp_valid, cmd_ready}, PADDR);
      n_err++;
    end
    PREADY = 1;
    tick();
    #3 PRESETn = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
        $display("FAIL areset_after%0d: got %b want 0001", i, {PSEL, PENABLE, rsp_valid, cmd_ready});
        n_err++;
      end
    end
    PREADY = 0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    for (int r = 0; r < 2; r++) begin
      cmd_valid = 1; cmd_addr = 8'h05; cmd_write = 0; PREADY = 0; PRDATA = 8'h3C;
      tick();
      cmd_valid = 0;
      tick();
      for (int i = 0; i < 3; i++) begin
        tick();
        n_cmp++;
        if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
          $display("FAIL to_wait%0d_%0d: got %b want 110", r, i, {PSEL, PENABLE, rsp_valid});
          n_err++;
        end
      end
      PREADY = (r == 1);
      tick();
      n_cmp++;
      if (r == 0 && {rsp_valid, rsp_timeout, rsp_rdata} !== {2'b11, 8'hFF}) begin
        $display("FAIL to_abort: got %b/%b/%h want 1/1/ff", rsp_valid, rsp_timeout, rsp_rdata);
        n_err++;
      end
      if (r == 1 && {rsp_valid, rsp_timeout, rsp_rdata} !== {2'b10, 8'h3C}) begin
        $display("FAIL to_limit_ready: got %b/%b/%h want 1/0/3c", rsp_valid, rsp_timeout, rsp_rdata);
        n_err++;
      end
      PREADY = 0;
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
    end
  endtask
`else
  task automatic test_timeout;
    cmd_valid = 1; cmd_addr = 8'h05; cmd_write = 0; PREADY = 0; PRDATA = 8'h3C;
    tick();
    cmd_valid = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid, rsp_timeout} !== 4'b1100) begin
        $display("FAIL no_to_wait%0d: got %b want 1100", i, {PSEL, PENABLE, rsp_valid, rsp_timeout});
        n_err++;
      end
    end
    PREADY = 1;
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_timeout, rsp_rdata} !== {2'b10, 8'h3C}) begin
      $display("FAIL no_to_resp: got %b/%b/%h want 1/0/3c", rsp_valid, rsp_timeout, rsp_rdata);
      n_err++;
    end
    PREADY = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_back_to_back();
    test_busy();
    test_async_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
